// File: rtl/wishbone_periph_mailbox_pkg.sv
// Shared types for the Wishbone peripheral mailbox.
//   mailbox_state_t : bus-side transfer FSM state (IDLE / WAIT / ACK)
//   lvl_width()     : width of an occupancy counter able to hold 0..depth
package wishbone_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } mailbox_state_t;

  function automatic int unsigned lvl_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wishbone_periph_mailbox_if.sv
// Wishbone B4 classic bus bundle between a cycle controller (master) and the
// mailbox responder (slave). Signal names are from the responder's viewpoint.
//   cyc_i, stb_i, we_i, dat_i : controller -> mailbox
//   dat_o, ack_o              : mailbox -> controller
interface wishbone_periph_mailbox_if #(
  parameter int unsigned DAT_WIDTH = 8
);

  logic                 cyc_i;
  logic                 stb_i;
  logic                 we_i;
  logic [DAT_WIDTH-1:0] dat_i;
  logic [DAT_WIDTH-1:0] dat_o;
  logic                 ack_o;

  modport master (
    output cyc_i, stb_i, we_i, dat_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, dat_i,
    output dat_o, ack_o
  );

endinterface

// File: rtl/wishbone_periph_mailbox_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i/din_i : write request and data (ignored when full unless popping)
//   pop_i        : read request (ignored when empty)
//   dout_o       : current head word, valid while !empty_o
//   full_o, empty_o, level_o : occupancy status, level 0..DEPTH
module sync_fifo
  import wishbone_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = lvl_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok_c;
  logic             pop_ok_c;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // A push into a full FIFO is accepted when a pop frees the slot on the same edge.
  assign pop_ok_c  = pop_i && !empty_o;
  assign push_ok_c = push_i && (!full_o || pop_ok_c);

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok_c && !pop_ok_c)      level_d = level_q + LW'(1);
    else if (!push_ok_c && pop_ok_c) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (push_ok_c) mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/wishbone_periph_mailbox.sv
// Wishbone B4 classic single-cycle mailbox responder. Bus writes push into a
// TX FIFO drained by local logic; bus reads pop an RX FIFO filled by local logic.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   wb (slave modport)   : cyc_i, stb_i, we_i, dat_i in; dat_o, ack_o out (registered)
//   tx_data/tx_valid/tx_ready : TX FIFO head, local pop handshake
//   rx_data/rx_valid/rx_ready : RX FIFO push handshake
//   tx_level, rx_level   : FIFO occupancy 0..DEPTH
// Build option WB_MAILBOX_NONBLOCK_EN: no wait states; writes to a full TX are
// dropped, reads of an empty RX return 0, and sticky overflow_o/underflow_o
// record those events until reset.
module wishbone_periph_mailbox
  import wishbone_pkg::*;
#(
  parameter int unsigned DAT_WIDTH = 8,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  wishbone_periph_mailbox_if.slave wb,
  output logic [DAT_WIDTH-1:0]     tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  input  logic [DAT_WIDTH-1:0]     rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [$clog2(DEPTH):0]   tx_level,
  output logic [$clog2(DEPTH):0]   rx_level
`ifdef WB_MAILBOX_NONBLOCK_EN
  ,
  output logic                     overflow_o,
  output logic                     underflow_o
`endif
);

  mailbox_state_t       state_q, state_d;
  logic                 ack_q, ack_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;

  logic                 req_c;
  logic                 go_ack_c;
  logic                 tx_push_c, tx_pop_c, tx_full_c, tx_empty_c;
  logic                 rx_push_c, rx_pop_c, rx_full_c, rx_empty_c;
  logic [DAT_WIDTH-1:0] rx_head_c;

`ifdef WB_MAILBOX_NONBLOCK_EN
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
`else
  logic                 can_complete_c;
`endif

  assign req_c     = wb.cyc_i && wb.stb_i;
  assign tx_valid  = !tx_empty_c;
  assign tx_pop_c  = tx_valid && tx_ready;
  assign rx_ready  = !rx_full_c;
  assign rx_push_c = rx_valid && rx_ready;

  assign wb.ack_o  = ack_q;
  assign wb.dat_o  = dat_q;

`ifdef WB_MAILBOX_NONBLOCK_EN
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`else
  // Decided on pre-edge occupancy: a same-cycle local pop does not unblock a write.
  assign can_complete_c = wb.we_i ? !tx_full_c : !rx_empty_c;
`endif

  sync_fifo #(
    .WIDTH (DAT_WIDTH),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tx_push_c),
    .din_i   (wb.dat_i),
    .pop_i   (tx_pop_c),
    .dout_o  (tx_data),
    .full_o  (tx_full_c),
    .empty_o (tx_empty_c),
    .level_o (tx_level)
  );

  sync_fifo #(
    .WIDTH (DAT_WIDTH),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rx_push_c),
    .din_i   (rx_data),
    .pop_i   (rx_pop_c),
    .dout_o  (rx_head_c),
    .full_o  (rx_full_c),
    .empty_o (rx_empty_c),
    .level_o (rx_level)
  );

  // State register; reset discards any pending transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state. ACK always returns to IDLE, so acks are at least two cycles apart.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
`ifdef WB_MAILBOX_NONBLOCK_EN
      IDLE: if (req_c) state_d = ACK;
      WAIT: state_d = IDLE;
      ACK:  state_d = IDLE;
`else
      IDLE: begin
        if (req_c) state_d = can_complete_c ? ACK : WAIT;
      end
      WAIT: begin
        if (!req_c)              state_d = IDLE;
        else if (can_complete_c) state_d = ACK;
      end
      ACK:  state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Transfer strobes and next values of the registered bus outputs.
  always_comb begin
    go_ack_c  = 1'b0;
    tx_push_c = 1'b0;
    rx_pop_c  = 1'b0;
`ifdef WB_MAILBOX_NONBLOCK_EN
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    go_ack_c    = (state_q == IDLE) && req_c;
    tx_push_c   = go_ack_c && wb.we_i && !tx_full_c;
    rx_pop_c    = go_ack_c && !wb.we_i && !rx_empty_c;
    if (go_ack_c && wb.we_i && tx_full_c)   overflow_d  = 1'b1;
    if (go_ack_c && !wb.we_i && rx_empty_c) underflow_d = 1'b1;
`else
    go_ack_c  = (state_q != ACK) && req_c && can_complete_c;
    tx_push_c = go_ack_c && wb.we_i;
    rx_pop_c  = go_ack_c && !wb.we_i;
`endif
    ack_d = go_ack_c;
    dat_d = rx_pop_c ? rx_head_c : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end

`ifdef WB_MAILBOX_NONBLOCK_EN
  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
`endif

endmodule
